// File: rtl/vga_tile_renderer_pkg.sv
// Shared constants for the tile-based VGA renderer: block codes, default
// palette, default 640x480 timing and the per-pixel pipeline flag bundle.
package vga_tile_renderer_pkg;

  localparam int DEF_BITS_PER_BLOCK = 2;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 29;

  typedef enum logic [1:0] {
    BLK_EMPTY = 2'd0,
    BLK_GREEN = 2'd1,
    BLK_RED   = 2'd2,
    BLK_WHITE = 2'd3
  } block_code_e;

  localparam logic [7:0] COLOR_EMPTY = 8'h00;
  localparam logic [7:0] COLOR_GREEN = 8'h1C;
  localparam logic [7:0] COLOR_RED   = 8'hE0;
  localparam logic [7:0] COLOR_WHITE = 8'hFF;

  // Everything the output stage needs to know about one pixel slot.
  typedef struct packed {
    logic active;
    logic in_grid;
    logic hs;
    logic vs;
    logic fs;
  } pix_flags_t;

  function automatic logic [7:0] pal_reset_color(input int idx);
    logic [7:0] c;
    if (idx > 3) begin
      c = COLOR_WHITE;
    end else begin
      case (block_code_e'(idx[1:0]))
        BLK_EMPTY: c = COLOR_EMPTY;
        BLK_GREEN: c = COLOR_GREEN;
        BLK_RED:   c = COLOR_RED;
        default:   c = COLOR_WHITE;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Programmable VGA raster counters with divider-free tile position tracking.
// Produces the stage-0 per-pixel flags for any downstream video pipeline.
module vga_timing_gen
  import vga_tile_renderer_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int TILE_W   = 40,
  parameter int TILE_H   = 40,
  parameter int GRID_W   = 16,
  parameter int GRID_H   = 12,
  parameter int HW       = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
  parameter int VW       = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
  input  logic          clk,
  input  logic          rst,
  output logic [HW-1:0] x_tile,
  output logic [VW-1:0] y_tile,
  output pix_flags_t    flags
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] XS_LAST = HW'(TILE_W - 1);
  localparam logic [VW-1:0] YS_LAST = VW'(TILE_H - 1);

  logic [HW-1:0] h_cnt, x_sub;
  logic [VW-1:0] v_cnt, y_sub;
  logic          h_last, v_last;

  assign h_last = (h_cnt == H_LAST);
  assign v_last = (v_cnt == V_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt  <= '0;
      v_cnt  <= '0;
      x_sub  <= '0;
      x_tile <= '0;
      y_sub  <= '0;
      y_tile <= '0;
    end else if (h_last) begin
      h_cnt  <= '0;
      x_sub  <= '0;
      x_tile <= '0;
      if (v_last) begin
        v_cnt  <= '0;
        y_sub  <= '0;
        y_tile <= '0;
      end else begin
        v_cnt <= v_cnt + 1'b1;
        if (y_sub == YS_LAST) begin
          y_sub  <= '0;
          y_tile <= y_tile + 1'b1;
        end else begin
          y_sub <= y_sub + 1'b1;
        end
      end
    end else begin
      h_cnt <= h_cnt + 1'b1;
      // x_tile keeps running through blanking; in_grid masks it there.
      if (x_sub == XS_LAST) begin
        x_sub  <= '0;
        x_tile <= x_tile + 1'b1;
      end else begin
        x_sub <= x_sub + 1'b1;
      end
    end
  end

  always_comb begin
    flags         = '0;
    flags.active  = (int'(h_cnt) < H_ACTIVE) && (int'(v_cnt) < V_ACTIVE);
    flags.in_grid = flags.active && (int'(x_tile) < GRID_W) && (int'(y_tile) < GRID_H);
    flags.hs      = (int'(h_cnt) >= H_ACTIVE + H_FP) &&
                    (int'(h_cnt) <  H_ACTIVE + H_FP + H_SYNC);
    flags.vs      = (int'(v_cnt) >= V_ACTIVE + V_FP) &&
                    (int'(v_cnt) <  V_ACTIVE + V_FP + V_SYNC);
    flags.fs      = (h_cnt == '0) && (v_cnt == '0);
  end

endmodule

// File: rtl/vga_tile_renderer.sv
// Tile-map VGA renderer: fetches tile codes from an external synchronous RAM,
// maps them through a writable palette and drives aligned RGB/HSync/VSync.
module vga_tile_renderer
  import vga_tile_renderer_pkg::*;
#(
  parameter int         H_ACTIVE       = DEF_H_ACTIVE,
  parameter int         H_FP           = DEF_H_FP,
  parameter int         H_SYNC         = DEF_H_SYNC,
  parameter int         H_BP           = DEF_H_BP,
  parameter int         V_ACTIVE       = DEF_V_ACTIVE,
  parameter int         V_FP           = DEF_V_FP,
  parameter int         V_SYNC         = DEF_V_SYNC,
  parameter int         V_BP           = DEF_V_BP,
  parameter logic       H_POL          = 1'b0,
  parameter logic       V_POL          = 1'b0,
  parameter int         TILE_W         = 40,
  parameter int         TILE_H         = 40,
  parameter int         GRID_W         = 16,
  parameter int         GRID_H         = 12,
  parameter int         BITS_PER_BLOCK = DEF_BITS_PER_BLOCK,
  parameter int         RAM_LATENCY    = 1,
  parameter logic [7:0] BORDER_COLOR   = 8'h00,
  parameter int         ADDR_W         = $clog2(GRID_W * GRID_H)
) (
  input  logic                      Clock,
  input  logic                      Reset,
  output logic [ADDR_W-1:0]         TileAddr,
  input  logic [BITS_PER_BLOCK-1:0] TileData,
  input  logic                      PalWe,
  input  logic [BITS_PER_BLOCK-1:0] PalIdx,
  input  logic [7:0]                PalColor,
  output logic [7:0]                RGB,
  output logic                      HSync,
  output logic                      VSync,
  output logic                      FrameStart
);

  localparam int HW    = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam int VW    = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);
  localparam int PAL_N = 2 ** BITS_PER_BLOCK;

  logic [HW-1:0]     x_tile;
  logic [VW-1:0]     y_tile;
  pix_flags_t        flags0;
  pix_flags_t        flag_pipe [RAM_LATENCY+1];
  pix_flags_t        f_out;
  logic [ADDR_W-1:0] tile_index;
  logic [7:0]        palette [PAL_N];

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .TILE_W   (TILE_W),
    .TILE_H   (TILE_H),
    .GRID_W   (GRID_W),
    .GRID_H   (GRID_H),
    .HW       (HW),
    .VW       (VW)
  ) u_timing (
    .clk    (Clock),
    .rst    (Reset),
    .x_tile (x_tile),
    .y_tile (y_tile),
    .flags  (flags0)
  );

  // Only evaluated in-grid, where both tile coordinates fit the address width.
  assign tile_index = ADDR_W'(y_tile) * ADDR_W'(GRID_W) + ADDR_W'(x_tile);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      TileAddr <= '0;
      for (int i = 0; i <= RAM_LATENCY; i++) flag_pipe[i] <= '0;
    end else begin
      if (flags0.in_grid) TileAddr <= tile_index;
      flag_pipe[0] <= flags0;
      for (int i = 1; i <= RAM_LATENCY; i++) flag_pipe[i] <= flag_pipe[i-1];
    end
  end

  // Flags that arrive together with TileData for the same pixel.
  assign f_out = flag_pipe[RAM_LATENCY];

  // A write and a read of the same entry on one edge: the read sees the old value.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < PAL_N; i++) palette[i] <= pal_reset_color(i);
    end else if (PalWe) begin
      palette[PalIdx] <= PalColor;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      RGB        <= 8'h00;
      HSync      <= ~H_POL;
      VSync      <= ~V_POL;
      FrameStart <= 1'b0;
    end else begin
      if (!f_out.active)      RGB <= 8'h00;
      else if (f_out.in_grid) RGB <= palette[TileData];
      else                    RGB <= BORDER_COLOR;
      HSync      <= f_out.hs ? H_POL : ~H_POL;
      VSync      <= f_out.vs ? V_POL : ~V_POL;
      FrameStart <= f_out.fs;
    end
  end

endmodule

// File: tb/tb_vga_tile_renderer.sv
// Bench for vga_tile_renderer: two small-raster instances checked cycle by cycle
// against a reference raster model, plus one default-timing instance.
module tb_vga_tile_renderer;

  localparam int HA = 8, HFP = 2, HSY = 3, HBP = 2, HT = 15;
  localparam int VA = 4, VFP = 1, VSY = 2, VBP = 1, VT = 8;
  localparam int TW = 3, TH = 2;
  localparam int GW_A = 3, GH_A = 2, LAT_A = 1;
  localparam int GW_B = 2, GH_B = 3, LAT_B = 3;
  localparam logic [7:0] BORDER_A = 8'h00;
  localparam logic [7:0] BORDER_B = 8'h5A;

  typedef struct packed {
    logic [1:0] kind;
    logic [1:0] code;
    logic       hs;
    logic       vs;
    logic       fs;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pal_we = 1'b0;
  logic [1:0] pal_idx = 2'd0;
  logic [7:0] pal_color = 8'h00;

  logic [2:0] addr_a, addr_b;
  logic [7:0] addr_c;
  logic [1:0] data_a = 2'd0, data_c = 2'd0;
  logic [1:0] rb [3] = '{default: 2'd0};
  logic [7:0] rgb_a, rgb_b, rgb_c;
  logic       hs_a, vs_a, fs_a, hs_b, vs_b, fs_b, hs_c, vs_c, fs_c;

  exp_t       exp_qa[$];
  exp_t       exp_qb[$];
  logic [7:0] pal_model [4];
  logic [7:0] pal_snap [4];
  int         mh = 0, mv = 0;
  bit         started = 1'b0;
  int         total = 0, bad = 0;

  always #5 clk = ~clk;

  function automatic logic [1:0] code_of(input int a);
    logic [1:0] r;
    r = a[1:0] ^ a[3:2];
    return r;
  endfunction

  // Synchronous tile RAMs of the two latencies under test.
  always @(posedge clk) begin
    data_a <= code_of(int'(addr_a));
    rb[0]  <= code_of(int'(addr_b));
    rb[1]  <= rb[0];
    rb[2]  <= rb[1];
    data_c <= addr_c[1:0];
  end

  vga_tile_renderer #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .H_POL(1'b0), .V_POL(1'b0), .TILE_W(TW), .TILE_H(TH),
    .GRID_W(GW_A), .GRID_H(GH_A), .BITS_PER_BLOCK(2),
    .RAM_LATENCY(LAT_A), .BORDER_COLOR(BORDER_A)
  ) dut_a (
    .Clock(clk), .Reset(rst), .TileAddr(addr_a), .TileData(data_a),
    .PalWe(pal_we), .PalIdx(pal_idx), .PalColor(pal_color),
    .RGB(rgb_a), .HSync(hs_a), .VSync(vs_a), .FrameStart(fs_a)
  );

  vga_tile_renderer #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .H_POL(1'b1), .V_POL(1'b1), .TILE_W(TW), .TILE_H(TH),
    .GRID_W(GW_B), .GRID_H(GH_B), .BITS_PER_BLOCK(2),
    .RAM_LATENCY(LAT_B), .BORDER_COLOR(BORDER_B)
  ) dut_b (
    .Clock(clk), .Reset(rst), .TileAddr(addr_b), .TileData(rb[2]),
    .PalWe(pal_we), .PalIdx(pal_idx), .PalColor(pal_color),
    .RGB(rgb_b), .HSync(hs_b), .VSync(vs_b), .FrameStart(fs_b)
  );

  vga_tile_renderer dut_c (
    .Clock(clk), .Reset(rst), .TileAddr(addr_c), .TileData(data_c),
    .PalWe(pal_we), .PalIdx(pal_idx), .PalColor(pal_color),
    .RGB(rgb_c), .HSync(hs_c), .VSync(vs_c), .FrameStart(fs_c)
  );

  function automatic exp_t make_entry(input int h, input int v, input int gw, input int gh);
    exp_t e;
    int   xt, yt;
    bit   act;
    act    = (h < HA) && (v < VA);
    xt     = h / TW;
    yt     = v / TH;
    e      = '0;
    e.kind = !act ? 2'd0 : ((xt < gw && yt < gh) ? 2'd2 : 2'd1);
    e.code = (e.kind == 2'd2) ? code_of(yt * gw + xt) : 2'd0;
    e.hs   = (h >= HA + HFP) && (h < HA + HFP + HSY);
    e.vs   = (v >= VA + VFP) && (v < VA + VFP + VSY);
    e.fs   = (h == 0) && (v == 0);
    return e;
  endfunction

  function automatic logic [10:0] resolve(input exp_t e, input logic [7:0] border,
                                          input logic hpol, input logic vpol);
    logic [7:0] c;
    case (e.kind)
      2'd2:    c = pal_snap[e.code];
      2'd1:    c = border;
      default: c = 8'h00;
    endcase
    return {c, e.hs ? hpol : ~hpol, e.vs ? vpol : ~vpol, e.fs};
  endfunction

  // One clock: scoreboard pops/compares both small instances, then pushes
  // the reference pixel for the counter position starting this cycle.
  task automatic tick();
    exp_t        e;
    logic [10:0] want;
    @(negedge clk);
    if (rst) begin
      started   = 1'b1;
      mh        = 0;
      mv        = 0;
      pal_model = '{8'h00, 8'h1C, 8'hE0, 8'hFF};
      pal_snap  = pal_model;
      want = resolve('0, BORDER_A, 1'b0, 1'b0);
      total++;
      if ({rgb_a, hs_a, vs_a, fs_a, addr_a} !== {want, 3'd0}) begin
        bad++;
        $display("FAIL reset_a t=%0t got=%h want=%h", $time, {rgb_a, hs_a, vs_a, fs_a, addr_a}, {want, 3'd0});
      end
      want = resolve('0, BORDER_B, 1'b1, 1'b1);
      total++;
      if ({rgb_b, hs_b, vs_b, fs_b, addr_b} !== {want, 3'd0}) begin
        bad++;
        $display("FAIL reset_b t=%0t got=%h want=%h", $time, {rgb_b, hs_b, vs_b, fs_b, addr_b}, {want, 3'd0});
      end
      exp_qa.delete();
      exp_qb.delete();
      repeat (LAT_A + 1) exp_qa.push_back('0);
      repeat (LAT_B + 1) exp_qb.push_back('0);
    end else if (started) begin
      if (pal_we) pal_model[pal_idx] = pal_color;
      total++;
      if (exp_qa.size() == 0) begin
        bad++;
        $display("FAIL pix_a t=%0t got=%h want=queued_entry", $time, {rgb_a, hs_a, vs_a, fs_a});
      end else begin
        e    = exp_qa.pop_front();
        want = resolve(e, BORDER_A, 1'b0, 1'b0);
        if ({rgb_a, hs_a, vs_a, fs_a} !== want) begin
          bad++;
          $display("FAIL pix_a t=%0t got=%h want=%h", $time, {rgb_a, hs_a, vs_a, fs_a}, want);
        end
      end
      total++;
      if (exp_qb.size() == 0) begin
        bad++;
        $display("FAIL pix_b t=%0t got=%h want=queued_entry", $time, {rgb_b, hs_b, vs_b, fs_b});
      end else begin
        e    = exp_qb.pop_front();
        want = resolve(e, BORDER_B, 1'b1, 1'b1);
        if ({rgb_b, hs_b, vs_b, fs_b} !== want) begin
          bad++;
          $display("FAIL pix_b t=%0t got=%h want=%h", $time, {rgb_b, hs_b, vs_b, fs_b}, want);
        end
      end
      total++;
      if (addr_a >= 3'd6 || addr_b >= 3'd4) begin
        bad++;
        $display("FAIL addr_range t=%0t got=%0d,%0d want=<6,<4", $time, addr_a, addr_b);
      end
    end
    if (started) begin
      exp_qa.push_back(make_entry(mh, mv, GW_A, GH_A));
      exp_qb.push_back(make_entry(mh, mv, GW_B, GH_B));
      mh++;
      if (mh == HT) begin
        mh = 0;
        mv++;
        if (mv == VT) mv = 0;
      end
      pal_snap = pal_model;
    end
  endtask

  task automatic test_reset();
    int fa, fb, fc;
    rst    = 1'b1;
    pal_we = 1'b0;
    repeat (3) tick();
    total++;
    if ({rgb_c, hs_c, vs_c, fs_c, addr_c} !== {8'h00, 1'b1, 1'b1, 1'b0, 8'h00}) begin
      bad++;
      $display("FAIL reset_c got=%h want=%h", {rgb_c, hs_c, vs_c, fs_c, addr_c}, {8'h00, 3'b110, 8'h00});
    end
    rst = 1'b0;
    fa = -1; fb = -1; fc = -1;
    for (int n = 1; n <= 12; n++) begin
      tick();
      if (fa < 0 && fs_a === 1'b1) fa = n;
      if (fb < 0 && fs_b === 1'b1) fb = n;
      if (fc < 0 && fs_c === 1'b1) fc = n;
    end
    total++;
    if (fa != LAT_A + 2) begin bad++; $display("FAIL first_fs_a got=%0d want=%0d", fa, LAT_A + 2); end
    total++;
    if (fb != LAT_B + 2) begin bad++; $display("FAIL first_fs_b got=%0d want=%0d", fb, LAT_B + 2); end
    total++;
    if (fc != 3) begin bad++; $display("FAIL first_fs_c got=%0d want=3", fc); end
  endtask

  task automatic test_frames();
    int hla, vla, fsa, hhb, vhb, fsb;
    hla = 0; vla = 0; fsa = 0; hhb = 0; vhb = 0; fsb = 0;
    for (int n = 0; n < 2 * HT * VT; n++) begin
      tick();
      if (hs_a === 1'b0) hla++;
      if (vs_a === 1'b0) vla++;
      if (fs_a === 1'b1) fsa++;
      if (hs_b === 1'b1) hhb++;
      if (vs_b === 1'b1) vhb++;
      if (fs_b === 1'b1) fsb++;
    end
    total++;
    if (hla != 2 * VT * HSY || hhb != 2 * VT * HSY) begin
      bad++;
      $display("FAIL hsync_width got=%0d,%0d want=%0d", hla, hhb, 2 * VT * HSY);
    end
    total++;
    if (vla != 2 * VSY * HT || vhb != 2 * VSY * HT) begin
      bad++;
      $display("FAIL vsync_width got=%0d,%0d want=%0d", vla, vhb, 2 * VSY * HT);
    end
    total++;
    if (fsa != 2 || fsb != 2) begin
      bad++;
      $display("FAIL frame_pulses got=%0d,%0d want=2", fsa, fsb);
    end
  endtask

  // Writes land on exactly the edge that latches a pixel using the same entry.
  task automatic test_palette_write();
    int guard;
    for (int k = 0; k < 6; k++) begin
      guard = 0;
      while (!(exp_qa.size() > 0 && exp_qa[0].kind == 2'd2 &&
               (k != 0 || exp_qa[0].code == 2'd1)) && guard < 300) begin
        tick();
        guard++;
      end
      total++;
      if (guard >= 300) begin bad++; $display("FAIL pal_wait got=%0d want=<300", guard); end
      pal_we    = 1'b1;
      pal_idx   = exp_qa[0].code;
      pal_color = (k == 0) ? 8'h03 : 8'($urandom_range(0, 255));
      tick();
      pal_we = 1'b0;
      repeat ($urandom_range(1, 20)) tick();
    end
    for (int k = 0; k < 20; k++) begin
      repeat ($urandom_range(0, 7)) tick();
      pal_we    = 1'b1;
      pal_idx   = 2'($urandom_range(0, 3));
      pal_color = 8'($urandom_range(0, 255));
      tick();
      pal_we = 1'b0;
    end
    repeat (30) tick();
  endtask

  task automatic test_back_to_back();
    pal_we = 1'b1;
    for (int i = 0; i < 10; i++) begin
      pal_idx   = 2'(i % 4);
      pal_color = 8'($urandom_range(0, 255));
      tick();
    end
    pal_idx = 2'd2;
    repeat (3) begin
      pal_color = 8'($urandom_range(0, 255));
      tick();
    end
    pal_we = 1'b0;
    repeat (2 * HT * VT) tick();
  endtask

  task automatic test_mid_reset();
    int guard, fa;
    guard = 0;
    while (!(mh == 5 && mv == 2) && guard < 200) begin
      tick();
      guard++;
    end
    total++;
    if (guard >= 200) begin bad++; $display("FAIL mid_reset_wait got=%0d want=<200", guard); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    fa = -1;
    for (int n = 1; n <= 10; n++) begin
      tick();
      if (fa < 0 && fs_a === 1'b1) fa = n;
    end
    total++;
    if (fa != LAT_A + 2) begin bad++; $display("FAIL mid_reset_fs got=%0d want=%0d", fa, LAT_A + 2); end
    repeat (150) tick();
  endtask

  task automatic test_default_line();
    int hl0, hl1, fsn, fs_at, nz, vlow;
    logic [7:0] px45, px620, px700;
    hl0 = 0; hl1 = 0; fsn = 0; fs_at = -1; nz = 0; vlow = 0;
    px45 = 8'hxx; px620 = 8'hxx; px700 = 8'hxx;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    for (int n = 1; n <= 1610; n++) begin
      tick();
      if (fs_c === 1'b1) begin fsn++; fs_at = n; end
      if (vs_c !== 1'b1) vlow++;
      if (n >= 3 && n < 803 && hs_c === 1'b0) hl0++;
      if (n >= 803 && n < 1603 && hs_c === 1'b0) hl1++;
      if (n >= 3 && n < 43 && rgb_c !== 8'h00) nz++;
      if (n == 48)  px45  = rgb_c;
      if (n == 623) px620 = rgb_c;
      if (n == 703) px700 = rgb_c;
    end
    total++;
    if (hl0 != 96 || hl1 != 96) begin bad++; $display("FAIL def_hsync got=%0d,%0d want=96", hl0, hl1); end
    total++;
    if (fsn != 1 || fs_at != 3) begin bad++; $display("FAIL def_fs got=%0d@%0d want=1@3", fsn, fs_at); end
    total++;
    if (vlow != 0) begin bad++; $display("FAIL def_vsync got=%0d want=0", vlow); end
    total++;
    if (nz != 0) begin bad++; $display("FAIL def_tile0 got=%0d want=0", nz); end
    total++;
    if (px45 !== 8'h1C) begin bad++; $display("FAIL def_px45 got=%h want=1c", px45); end
    total++;
    if (px620 !== 8'hFF) begin bad++; $display("FAIL def_px620 got=%h want=ff", px620); end
    total++;
    if (px700 !== 8'h00) begin bad++; $display("FAIL def_blank got=%h want=00", px700); end
  endtask

  initial begin
    test_reset();
    test_frames();
    test_palette_write();
    test_back_to_back();
    test_mid_reset();
    test_default_line();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog t=%0t got=running want=finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
